// File: rtl/dct_sched_pkg.sv
// Shared sizing for the DCT block scheduler: requester count, tag width and block width.
// Blocks are 64 coefficient words, row-major, word i at bits [i*IN_W +: IN_W].
package dct_sched_pkg;

  localparam int N_REQ_DEF     = 3;
  localparam int IN_W_DEF      = 32;
  localparam int TAG_DEPTH_DEF = 4;
  localparam int WORDS_PER_BLK = 64;

  function automatic int blk_w(input int in_w);
    return WORDS_PER_BLK * in_w;
  endfunction

  // A single requester still needs a 1-bit tag so the store has a real width.
  function automatic int tag_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  localparam int TAG_W = tag_w(N_REQ_DEF);

endpackage

// File: rtl/dct_tag_fifo.sv
// Owner-tag store for blocks in flight; head visible combinationally, zero-latency pop.
// Pushes are refused when full even if a pop happens in the same cycle.
module dct_tag_fifo
  import dct_sched_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH_DEF,
  parameter int W     = TAG_W,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/dct_block_scheduler.sv
// Round-robin arbiter sharing one DCT core among N_REQ requesters, routing results by owner tag.
// Zero added latency both ways; stalls requesters when TAG_DEPTH blocks are in flight.
module dct_block_scheduler
  import dct_sched_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int IN_W      = IN_W_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF,
  localparam int BW       = blk_w(IN_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*BW-1:0] req_block,
  output logic [N_REQ-1:0]   req_ready,
  output logic               dct_in_valid,
  output logic [BW-1:0]      dct_in_block,
  input  logic               dct_in_ready,
  input  logic               dct_out_valid,
  input  logic [BW-1:0]      dct_out_block,
  output logic               dct_out_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [BW-1:0]      rsp_block,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic               busy,
  output logic [15:0]        done_cnt,
  output logic               proto_err
);

  localparam int TW = tag_w(N_REQ);
  localparam int CW = $clog2(TAG_DEPTH + 1);

  logic [TW-1:0] r_rr_ptr;
  logic [15:0]   r_done_cnt;
  logic          r_proto_err;

  logic          w_gnt_vld;
  logic [TW-1:0] w_gnt_idx;
  int            w_idx;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [TW-1:0] w_head;
  logic          w_head_ok;
  logic          w_push;
  logic          w_pop;

  // Descending scan so the smallest offset from r_rr_ptr is written last and wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (req_valid[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = TW'(w_idx);
      end
    end
  end

  assign dct_in_valid = rst_n && (|req_valid) && !w_full;
  assign dct_in_block = w_gnt_vld ? req_block[int'(w_gnt_idx)*BW +: BW] : '0;
  assign w_push       = dct_in_valid && dct_in_ready;

  always_comb begin
    req_ready = '0;
    if (rst_n && w_gnt_vld && dct_in_ready && !w_full) req_ready[w_gnt_idx] = 1'b1;
  end

  assign w_head_ok     = rst_n && !w_empty && (int'(w_head) < N_REQ);
  assign dct_out_ready = w_head_ok && rsp_ready[w_head];
  assign w_pop         = dct_out_valid && dct_out_ready;
  assign rsp_block     = dct_out_block;

  always_comb begin
    rsp_valid = '0;
    if (w_head_ok) rsp_valid[w_head] = dct_out_valid;
  end

  dct_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (TW),
    .CW    (CW)
  ) u_tag_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (w_gnt_idx),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_done_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) r_rr_ptr <= (int'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
      if (w_pop) r_done_cnt <= r_done_cnt + 16'd1;
      // A result with no owner on record can never be routed; latch it until reset.
      if (dct_out_valid && w_empty) r_proto_err <= 1'b1;
    end
  end

  assign busy      = rst_n && (w_count != '0);
  assign done_cnt  = r_done_cnt;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Directed bench for dct_block_scheduler; the DCT core handshake is driven by hand.
module tb_dct_block_scheduler;
  import dct_sched_pkg::*;

  localparam int NR = 3;
  localparam int IW = 32;
  localparam int TD = 4;
  localparam int BW = blk_w(IW);

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*BW-1:0]  req_block;
  logic [NR-1:0]     req_ready;
  logic              dct_in_valid;
  logic [BW-1:0]     dct_in_block;
  logic              dct_in_ready;
  logic              dct_out_valid;
  logic [BW-1:0]     dct_out_block;
  logic              dct_out_ready;
  logic [NR-1:0]     rsp_valid;
  logic [BW-1:0]     rsp_block;
  logic [NR-1:0]     rsp_ready;
  logic              busy;
  logic [15:0]       done_cnt;
  logic              proto_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc;
  logic [NR-1:0] mid_exp [3];

  dct_block_scheduler #(.N_REQ(NR), .IN_W(IW), .TAG_DEPTH(TD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_block     (req_block),
    .req_ready     (req_ready),
    .dct_in_valid  (dct_in_valid),
    .dct_in_block  (dct_in_block),
    .dct_in_ready  (dct_in_ready),
    .dct_out_valid (dct_out_valid),
    .dct_out_block (dct_out_block),
    .dct_out_ready (dct_out_ready),
    .rsp_valid     (rsp_valid),
    .rsp_block     (rsp_block),
    .rsp_ready     (rsp_ready),
    .busy          (busy),
    .done_cnt      (done_cnt),
    .proto_err     (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = '1;
    dct_in_ready  = 1'b1;
    dct_out_valid = 1'b1;
    dct_out_block = '0;
    rsp_ready     = '1;
    req_block     = '0;
    for (int r = 0; r < NR; r++)
      for (int i = 0; i < 64; i++)
        req_block[(r*64+i)*IW +: IW] = IW'(r*1000 + i + 1);

    // Outputs held quiet while reset is asserted, even with live inputs
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_in_valid", 64'(dct_in_valid), 64'd0);
    chk("rst_out_ready", 64'(dct_out_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);

    req_valid     = '0;
    dct_out_valid = 1'b0;
    rst_n         = 1'b1;
    settle();
    chk("idle_blk_zero", 64'(dct_in_block == '0), 64'd1);
    chk("idle_in_valid", 64'(dct_in_valid), 64'd0);

    // All requesters busy, core always ready: grants rotate, results follow one cycle later
    for (int k = 0; k < 6; k++) begin
      req_valid     = '1;
      dct_out_valid = (k > 0);
      dct_out_block[IW-1:0] = IW'(32'hD000 + k);
      settle();
      chk("rr_req_ready", 64'(req_ready), 64'(1 << (k % 3)));
      chk("rr_in_blk", 64'(dct_in_block[IW-1:0]), 64'((k % 3) * 1000 + 1));
      chk("rr_in_blk_full", 64'(dct_in_block === req_block[(k % 3)*BW +: BW]), 64'd1);
      if (k > 0) begin
        chk("rr_rsp_valid", 64'(rsp_valid), 64'(1 << ((k - 1) % 3)));
        chk("rr_rsp_blk", 64'(rsp_block[IW-1:0]), 64'(32'hD000 + k));
      end
      tick();
    end
    req_valid     = '0;
    dct_out_valid = 1'b1;
    settle();
    chk("rr_last_rsp", 64'(rsp_valid), 64'b100);
    tick();
    dct_out_valid = 1'b0;
    settle();
    chk("rr_done_cnt", 64'(done_cnt), 64'd6);
    chk("rr_busy", 64'(busy), 64'd0);

    // Core output stalled, requester 1 streaming: exactly TAG_DEPTH accepts
    req_valid = 3'b010;
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("stall_req_ready", 64'(req_ready), (k < 4) ? 64'b010 : 64'd0);
      if (req_ready[1]) n_acc++;
      tick();
    end
    chk("stall_accepts", 64'(n_acc), 64'd4);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_in_valid", 64'(dct_in_valid), 64'd0);
    dct_out_valid = 1'b1;
    rsp_ready     = 3'b010;
    settle();
    chk("full_pop_req_ready", 64'(req_ready), 64'd0);
    chk("full_pop_out_ready", 64'(dct_out_ready), 64'd1);
    chk("full_pop_rsp_valid", 64'(rsp_valid), 64'b010);
    tick();
    dct_out_valid = 1'b0;
    settle();
    chk("after_pop_req_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid     = '0;
    dct_out_valid = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    dct_out_valid = 1'b0;
    settle();
    chk("stall_done_cnt", 64'(done_cnt), 64'd11);
    chk("stall_busy_end", 64'(busy), 64'd0);

    // Head owner 2 withholds rsp_ready, then releases alongside a new push
    req_valid = '1;
    rsp_ready = '1;
    settle();
    chk("hold_grant2", 64'(req_ready), 64'b100);
    tick();
    req_valid = 3'b001;
    settle();
    chk("hold_grant0", 64'(req_ready), 64'b001);
    tick();
    req_valid     = '0;
    dct_out_valid = 1'b1;
    rsp_ready     = 3'b011;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("hold_out_ready", 64'(dct_out_ready), 64'd0);
      chk("hold_rsp_valid", 64'(rsp_valid), 64'b100);
      chk("hold_done_cnt", 64'(done_cnt), 64'd11);
      tick();
    end
    rsp_ready = '1;
    req_valid = 3'b010;
    settle();
    chk("sim_req_ready", 64'(req_ready), 64'b010);
    chk("sim_out_ready", 64'(dct_out_ready), 64'd1);
    tick();
    chk("sim_done_cnt", 64'(done_cnt), 64'd12);
    req_valid = '0;
    settle();
    chk("order_rsp0", 64'(rsp_valid), 64'b001);
    tick();
    chk("order_busy1", 64'(busy), 64'd1);
    settle();
    chk("order_rsp1", 64'(rsp_valid), 64'b010);
    tick();
    dct_out_valid = 1'b0;
    settle();
    chk("order_busy0", 64'(busy), 64'd0);
    chk("order_done_cnt", 64'(done_cnt), 64'd14);

    // Result with no block in flight
    dct_out_valid = 1'b1;
    settle();
    chk("perr_out_ready", 64'(dct_out_ready), 64'd0);
    chk("perr_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    dct_out_valid = 1'b0;
    chk("perr_set", 64'(proto_err), 64'd1);
    tick();
    tick();
    chk("perr_sticky", 64'(proto_err), 64'd1);
    chk("perr_done_cnt", 64'(done_cnt), 64'd14);

    // Three blocks in flight, then a one-cycle reset
    mid_exp[0] = 3'b100;
    mid_exp[1] = 3'b001;
    mid_exp[2] = 3'b010;
    req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("mid_grant", 64'(req_ready), 64'(mid_exp[k]));
      tick();
    end
    chk("mid_busy", 64'(busy), 64'd1);
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("post_rst_proto_err", 64'(proto_err), 64'd0);
    req_valid = '1;
    settle();
    chk("post_rst_grant0", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    settle();
    chk("post_rst_busy1", 64'(busy), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
